// File: rtl/datamover_package.sv
// -----------------------------------------------------------------------------
// datamover_package
//
// Shared types for the datamover job controller.
//   dm_state_e  - job controller FSM states
//   job_desc_t  - queued job descriptor {mask, rep, id}
//
// The descriptor is sized for the largest supported configuration
// (8 channels, 16-bit repeat count, 16-bit tag). Instances that use narrower
// fields zero-pad the upper bits; those bits are constant and drop out in
// synthesis.
// -----------------------------------------------------------------------------
package datamover_package;

  localparam int unsigned DM_MAX_CH    = 8;
  localparam int unsigned DM_MAX_REP_W = 16;
  localparam int unsigned DM_MAX_ID_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STARTING = 2'd1,
    ST_WORKING  = 2'd2,
    ST_FINISHED = 2'd3
  } dm_state_e;

  typedef struct packed {
    logic [DM_MAX_CH-1:0]    mask;
    logic [DM_MAX_REP_W-1:0] rep;
    logic [DM_MAX_ID_W-1:0]  id;
  } job_desc_t;

  // A repeat count of 0 is treated as 1, so the passes still owed after the
  // first one are max(rep,1)-1.
  function automatic logic [DM_MAX_REP_W-1:0] first_passes_left(
    input logic [DM_MAX_REP_W-1:0] rep
  );
    return (rep == '0) ? '0 : rep - DM_MAX_REP_W'(1);
  endfunction

endpackage

// File: rtl/datamover_job_fifo.sv
// -----------------------------------------------------------------------------
// datamover_job_fifo
//
// Small synchronous FIFO holding job descriptors.
//   clk_i    clock
//   rst_i    async active-high reset (pointers/count)
//   flush_i  sync flush, empties the queue on the next edge
//   push_i   write request, ignored when full (no push-through)
//   data_i   write data
//   pop_i    read request, ignored when empty
//   data_o   head entry (valid when !empty_o)
//   full_o   queue full
//   empty_o  queue empty
//   count_o  number of stored entries
//
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module datamover_job_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      // Simultaneous push and pop leave the count unchanged.
      if (do_push && !do_pop) begin
        count_q <= count_q + (PTR_W + 1)'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - (PTR_W + 1)'(1);
      end
    end
  end

  // Storage carries no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/datamover_job_ctrl.sv
// -----------------------------------------------------------------------------
// datamover_job_ctrl
//
// Queues datamover jobs and sequences them over a set of streamer channels.
// Each job starts the masked channels, waits until every masked sink has
// reported done and drained its TCDM FIFO, repeats for the requested number
// of passes, then signals completion with a tag and a core event.
//
// Ports
//   clk_i            clock
//   rst_i            async active-high reset
//   clear_i          sync soft clear (flush queue, abandon current job)
//   job_valid_i      descriptor valid
//   job_ready_o      descriptor accepted when valid & ready
//   job_ch_mask_i    channels used by the job
//   job_repeat_i     pass count, 0 means 1
//   job_id_i         job tag
//   ch_start_o       one-cycle start pulse per channel
//   ch_sink_done_i   sink done pulse per channel
//   ch_fifo_empty_i  channel TCDM FIFO empty
//   done_o           one-cycle job-complete pulse
//   done_id_o        tag of completed job, 0 when done_o is low
//   evt_o            core event, all ones together with done_o
//   busy_o           FSM not idle or queue not empty
//   queue_count_o    number of queued jobs
// -----------------------------------------------------------------------------
module datamover_job_ctrl
  import datamover_package::*;
#(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned REP_W       = 8,
  parameter int unsigned ID_W        = 4,
  parameter int unsigned N_CORES     = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clear_i,
  input  logic                           job_valid_i,
  output logic                           job_ready_o,
  input  logic [N_CH-1:0]                job_ch_mask_i,
  input  logic [REP_W-1:0]               job_repeat_i,
  input  logic [ID_W-1:0]                job_id_i,
  output logic [N_CH-1:0]                ch_start_o,
  input  logic [N_CH-1:0]                ch_sink_done_i,
  input  logic [N_CH-1:0]                ch_fifo_empty_i,
  output logic                           done_o,
  output logic [ID_W-1:0]                done_id_o,
  output logic [N_CORES-1:0]             evt_o,
  output logic                           busy_o,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count_o
);

  localparam int unsigned DESC_W = $bits(job_desc_t);

  dm_state_e               state_q;
  dm_state_e               state_d;
  logic [N_CH-1:0]         work_mask_q;
  logic [N_CH-1:0]         work_mask_d;
  logic [REP_W-1:0]        work_rem_q;
  logic [REP_W-1:0]        work_rem_d;
  logic [ID_W-1:0]         work_id_q;
  logic [ID_W-1:0]         work_id_d;
  logic [N_CH-1:0]         seen_q;
  logic [N_CH-1:0]         seen_d;
  logic                    ready_en_q;

  job_desc_t               push_desc;
  job_desc_t               head_desc;
  logic [DM_MAX_REP_W-1:0] head_rem;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic [N_CH-1:0]         ch_ok;
  logic                    pass_done;
  logic                    unused_desc_bits;

  // Pack the incoming descriptor into the shared (max-width) layout.
  always_comb begin
    push_desc                 = '0;
    push_desc.mask[N_CH-1:0]  = job_ch_mask_i;
    push_desc.rep[REP_W-1:0]  = job_repeat_i;
    push_desc.id[ID_W-1:0]    = job_id_i;
  end

  // ready_en_q holds job_ready_o low until the first edge after reset.
  assign job_ready_o = ready_en_q && !fifo_full && !clear_i;
  assign fifo_push   = job_valid_i && job_ready_o;

  datamover_job_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (DESC_W)
  ) u_job_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (clear_i),
    .push_i  (fifo_push),
    .data_i  (push_desc),
    .pop_i   (fifo_pop),
    .data_o  (head_desc),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (queue_count_o)
  );

  assign head_rem = first_passes_left(head_desc.rep);

  // Padding bits above the configured widths are always zero.
  assign unused_desc_bits = ^{head_desc, head_rem};

  // A channel is finished for this pass once its sink has reported done
  // (earlier or right now) and its FIFO has drained; unmasked channels
  // never hold the pass back.
  assign ch_ok     = ~work_mask_q | ((seen_q | ch_sink_done_i) & ch_fifo_empty_i);
  assign pass_done = &ch_ok;

  always_comb begin
    state_d     = state_q;
    work_mask_d = work_mask_q;
    work_rem_d  = work_rem_q;
    work_id_d   = work_id_q;
    seen_d      = seen_q;
    fifo_pop    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          work_mask_d = head_desc.mask[N_CH-1:0];
          work_rem_d  = head_rem[REP_W-1:0];
          work_id_d   = head_desc.id[ID_W-1:0];
          // An empty mask has nothing to move: report completion directly.
          state_d     = (head_desc.mask[N_CH-1:0] == '0) ? ST_FINISHED : ST_STARTING;
        end
      end
      ST_STARTING: begin
        seen_d  = '0;
        state_d = ST_WORKING;
      end
      ST_WORKING: begin
        seen_d = seen_q | (ch_sink_done_i & work_mask_q);
        if (pass_done) begin
          if (work_rem_q != '0) begin
            work_rem_d = work_rem_q - REP_W'(1);
            state_d    = ST_STARTING;
          end else begin
            state_d    = ST_FINISHED;
          end
        end
      end
      ST_FINISHED: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Soft clear abandons everything, including a pass that completes now.
    if (clear_i) begin
      state_d     = ST_IDLE;
      work_mask_d = '0;
      work_rem_d  = '0;
      work_id_d   = '0;
      seen_d      = '0;
      fifo_pop    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      work_mask_q <= '0;
      work_rem_q  <= '0;
      work_id_q   <= '0;
      seen_q      <= '0;
      ready_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_mask_q <= work_mask_d;
      work_rem_q  <= work_rem_d;
      work_id_q   <= work_id_d;
      seen_q      <= seen_d;
      ready_en_q  <= 1'b1;
    end
  end

  assign ch_start_o = (state_q == ST_STARTING) ? work_mask_q : '0;
  assign done_o     = (state_q == ST_FINISHED) && !clear_i;
  assign done_id_o  = done_o ? work_id_q : '0;
  assign evt_o      = {N_CORES{done_o}};
  assign busy_o     = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_datamover_job_ctrl.sv
module tb_datamover_job_ctrl;

  localparam int N_CH        = 2;
  localparam int QUEUE_DEPTH = 4;
  localparam int REP_W       = 8;
  localparam int ID_W        = 4;
  localparam int N_CORES     = 8;

  logic                         clk = 1'b0;
  logic                         rst_i;
  logic                         clear_i;
  logic                         job_valid_i;
  logic                         job_ready_o;
  logic [N_CH-1:0]              job_ch_mask_i;
  logic [REP_W-1:0]             job_repeat_i;
  logic [ID_W-1:0]              job_id_i;
  logic [N_CH-1:0]              ch_start_o;
  logic [N_CH-1:0]              ch_sink_done_i;
  logic [N_CH-1:0]              ch_fifo_empty_i;
  logic                         done_o;
  logic [ID_W-1:0]              done_id_o;
  logic [N_CORES-1:0]           evt_o;
  logic                         busy_o;
  logic [$clog2(QUEUE_DEPTH):0] queue_count_o;

  always #5 clk = ~clk;

  datamover_job_ctrl #(
    .N_CH        (N_CH),
    .QUEUE_DEPTH (QUEUE_DEPTH),
    .REP_W       (REP_W),
    .ID_W        (ID_W),
    .N_CORES     (N_CORES)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .clear_i         (clear_i),
    .job_valid_i     (job_valid_i),
    .job_ready_o     (job_ready_o),
    .job_ch_mask_i   (job_ch_mask_i),
    .job_repeat_i    (job_repeat_i),
    .job_id_i        (job_id_i),
    .ch_start_o      (ch_start_o),
    .ch_sink_done_i  (ch_sink_done_i),
    .ch_fifo_empty_i (ch_fifo_empty_i),
    .done_o          (done_o),
    .done_id_o       (done_id_o),
    .evt_o           (evt_o),
    .busy_o          (busy_o),
    .queue_count_o   (queue_count_o)
  );

  int              n_checks = 0;
  int              n_fail   = 0;
  int              cyc      = 0;
  int              start_pulses = 0;
  int              done_pulses  = 0;
  logic [ID_W-1:0] exp_ids[$];
  int              done_times[$];
  logic [N_CH-1:0] prev_start = '0;
  logic [ID_W-1:0] mon_exp;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard side: every done_o pops the oldest accepted job tag.
  always @(negedge clk) begin
    if (ch_start_o !== '0) begin
      start_pulses++;
      n_checks++;
      if (prev_start !== '0) begin
        n_fail++;
        $display("FAIL start_one_cycle: ch_start_o=%b also high previous cycle, required single-cycle pulse", ch_start_o);
      end
    end
    prev_start = ch_start_o;
    if (done_o === 1'b1) begin
      done_pulses++;
      done_times.push_back(cyc);
      n_checks++;
      if (exp_ids.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: done_o=1 id=%0d, required no done", done_id_o);
      end else begin
        mon_exp = exp_ids.pop_front();
        if (done_id_o !== mon_exp) begin
          n_fail++;
          $display("FAIL sb_done_id: done_id_o=%0d required %0d", done_id_o, mon_exp);
        end
      end
      n_checks++;
      if (evt_o !== {N_CORES{1'b1}}) begin
        n_fail++;
        $display("FAIL evt_with_done: evt_o=%b required all ones", evt_o);
      end
    end else begin
      n_checks++;
      if (done_id_o !== '0 || evt_o !== '0) begin
        n_fail++;
        $display("FAIL quiet_outputs: done_id_o=%0d evt_o=%b required 0 and 0", done_id_o, evt_o);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic push_job(input logic [N_CH-1:0] m, input logic [REP_W-1:0] r,
                          input logic [ID_W-1:0] id);
    bit acc;
    acc = 1'b0;
    job_valid_i   = 1'b1;
    job_ch_mask_i = m;
    job_repeat_i  = r;
    job_id_i      = id;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk);
      if (job_ready_o === 1'b1) begin
        acc = 1'b1;
        exp_ids.push_back(id);
      end
      tick(1);
    end
    job_valid_i = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: job id %0d not accepted, required acceptance", id);
    end
  endtask

  // Returns at the negedge of the cycle where ch_start_o is first seen high.
  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (ch_start_o !== '0) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic test_reset();
    tick(2);
    @(negedge clk);
    n_checks++; if (job_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: job_ready_o=%b required 0", job_ready_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: busy_o=%b required 0", busy_o); end
    n_checks++; if (queue_count_o !== '0) begin n_fail++; $display("FAIL reset_count: queue_count_o=%0d required 0", queue_count_o); end
    n_checks++; if (ch_start_o !== '0 || done_o !== 1'b0) begin n_fail++; $display("FAIL reset_outputs: ch_start_o=%b done_o=%b required 0 0", ch_start_o, done_o); end
    #1 rst_i = 1'b0;
    #1;
    n_checks++; if (job_ready_o !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge: job_ready_o=%b required 0", job_ready_o); end
    tick(1);
    @(negedge clk);
    n_checks++; if (job_ready_o !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: job_ready_o=%b required 1", job_ready_o); end
    tick(1);
  endtask

  task automatic test_single_pass();
    int s0;
    s0 = start_pulses;
    push_job(2'b11, 8'd0, 4'd5);
    @(negedge clk);
    n_checks++; if (ch_start_o !== 2'b00) begin n_fail++; $display("FAIL single_early_start: ch_start_o=%b required 00", ch_start_o); end
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL single_busy: busy_o=%b required 1", busy_o); end
    tick(1);
    @(negedge clk);
    n_checks++; if (ch_start_o !== 2'b11) begin n_fail++; $display("FAIL single_start: ch_start_o=%b required 11", ch_start_o); end
    tick(8);
    ch_sink_done_i = 2'b01;
    @(negedge clk);
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL single_ch0_only: done_o=%b required 0", done_o); end
    tick(1);
    ch_sink_done_i = 2'b00;
    tick(3);
    ch_sink_done_i = 2'b10;
    @(negedge clk);
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL single_done_early: done_o=%b required 0", done_o); end
    tick(1);
    ch_sink_done_i = 2'b00;
    @(negedge clk);
    n_checks++; if (done_o !== 1'b1 || done_id_o !== 4'd5) begin n_fail++; $display("FAIL single_done: done_o=%b id=%0d required 1 id 5", done_o, done_id_o); end
    tick(1);
    @(negedge clk);
    n_checks++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL single_after: done_o=%b busy_o=%b required 0 0", done_o, busy_o); end
    n_checks++; if (start_pulses - s0 !== 1) begin n_fail++; $display("FAIL single_start_count: %0d start pulses, required 1", start_pulses - s0); end
    tick(1);
  endtask

  task automatic test_repeat();
    int s0;
    int d0;
    bit ok;
    s0 = start_pulses;
    d0 = done_pulses;
    push_job(2'b01, 8'd3, 4'd3);
    wait_start(ok);
    n_checks++; if (!ok || ch_start_o !== 2'b01) begin n_fail++; $display("FAIL repeat_first_start: ch_start_o=%b required 01", ch_start_o); end
    for (int p = 0; p < 3; p++) begin
      tick(3);
      ch_sink_done_i = 2'b01;
      @(negedge clk);
      n_checks++; if (done_o !== 1'b0 || ch_start_o !== 2'b00) begin n_fail++; $display("FAIL repeat_pass_cycle: pass %0d done_o=%b ch_start_o=%b required 0 00", p, done_o, ch_start_o); end
      tick(1);
      ch_sink_done_i = 2'b00;
      @(negedge clk);
      if (p < 2) begin
        n_checks++; if (ch_start_o !== 2'b01) begin n_fail++; $display("FAIL repeat_restart: pass %0d ch_start_o=%b required 01", p, ch_start_o); end
      end else begin
        n_checks++; if (done_o !== 1'b1 || done_id_o !== 4'd3) begin n_fail++; $display("FAIL repeat_done: done_o=%b id=%0d required 1 id 3", done_o, done_id_o); end
      end
    end
    tick(2);
    n_checks++; if (start_pulses - s0 !== 3) begin n_fail++; $display("FAIL repeat_start_count: %0d pulses, required 3", start_pulses - s0); end
    n_checks++; if (done_pulses - d0 !== 1) begin n_fail++; $display("FAIL repeat_done_count: %0d dones, required 1", done_pulses - d0); end
  endtask

  task automatic test_mask_zero();
    int s0;
    s0 = start_pulses;
    push_job(2'b00, 8'd0, 4'd9);
    @(negedge clk);
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL mask0_early: done_o=%b required 0", done_o); end
    tick(1);
    @(negedge clk);
    n_checks++; if (done_o !== 1'b1 || done_id_o !== 4'd9) begin n_fail++; $display("FAIL mask0_done: done_o=%b id=%0d required 1 id 9", done_o, done_id_o); end
    tick(2);
    n_checks++; if (start_pulses !== s0) begin n_fail++; $display("FAIL mask0_no_start: %0d pulses, required 0", start_pulses - s0); end
  endtask

  task automatic test_fifo_not_empty();
    bit ok;
    push_job(2'b01, 8'd0, 4'd7);
    wait_start(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL fifo_start: no ch_start_o seen, required 01"); end
    tick(1);
    ch_fifo_empty_i = 2'b10;
    ch_sink_done_i  = 2'b01;
    @(negedge clk);
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL fifo_pulse_cycle: done_o=%b required 0", done_o); end
    tick(1);
    ch_sink_done_i = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL fifo_wait: cycle %0d done_o=%b required 0", i, done_o); end
      tick(1);
    end
    ch_fifo_empty_i = 2'b11;
    @(negedge clk);
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL fifo_drain_cycle: done_o=%b required 0", done_o); end
    tick(1);
    @(negedge clk);
    n_checks++; if (done_o !== 1'b1 || done_id_o !== 4'd7) begin n_fail++; $display("FAIL fifo_done: done_o=%b id=%0d required 1 id 7", done_o, done_id_o); end
    tick(1);
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit acc;
    done_times.delete();
    push_job(2'b01, 8'd0, 4'd0);
    wait_start(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_blocker_start: no ch_start_o seen, required 01"); end
    tick(1);
    for (int i = 1; i <= 4; i++) push_job(2'b00, 8'd0, 4'(i));
    @(negedge clk);
    n_checks++; if (queue_count_o !== 3'd4) begin n_fail++; $display("FAIL full_count: queue_count_o=%0d required 4", queue_count_o); end
    n_checks++; if (job_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready: job_ready_o=%b required 0", job_ready_o); end
    tick(1);
    job_valid_i   = 1'b1;
    job_ch_mask_i = 2'b00;
    job_repeat_i  = 8'd0;
    job_id_i      = 4'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (job_ready_o !== 1'b0 || queue_count_o !== 3'd4) begin n_fail++; $display("FAIL full_hold: job_ready_o=%b count=%0d required 0 and 4", job_ready_o, queue_count_o); end
      tick(1);
    end
    ch_sink_done_i = 2'b01;
    tick(1);
    ch_sink_done_i = 2'b00;
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clk);
      if (job_ready_o === 1'b1) begin
        acc = 1'b1;
        exp_ids.push_back(4'd5);
        n_checks++; if (queue_count_o !== 3'd3) begin n_fail++; $display("FAIL fifth_after_pop: queue_count_o=%0d required 3", queue_count_o); end
      end
      tick(1);
    end
    job_valid_i = 1'b0;
    n_checks++; if (!acc) begin n_fail++; $display("FAIL fifth_accept: not accepted, required acceptance"); end
    for (int t = 0; t < 100 && exp_ids.size() != 0; t++) tick(1);
    tick(2);
    n_checks++; if (exp_ids.size() != 0) begin n_fail++; $display("FAIL b2b_drain: %0d jobs outstanding, required 0", exp_ids.size()); end
    n_checks++;
    if (done_times.size() != 6) begin
      n_fail++; $display("FAIL b2b_done_count: %0d dones, required 6", done_times.size());
    end else begin
      for (int i = 1; i < 6; i++) begin
        n_checks++; if (done_times[i] - done_times[i-1] != 2) begin n_fail++; $display("FAIL b2b_spacing: gap %0d is %0d cycles, required 2", i, done_times[i] - done_times[i-1]); end
      end
    end
  endtask

  task automatic test_clear();
    bit ok;
    push_job(2'b11, 8'd0, 4'd10);
    wait_start(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL clear_start: no ch_start_o seen, required 11"); end
    tick(1);
    push_job(2'b01, 8'd0, 4'd11);
    push_job(2'b01, 8'd0, 4'd12);
    @(negedge clk);
    n_checks++; if (queue_count_o !== 3'd2) begin n_fail++; $display("FAIL clear_pre_count: queue_count_o=%0d required 2", queue_count_o); end
    tick(1);
    clear_i = 1'b1;
    @(negedge clk);
    n_checks++; if (job_ready_o !== 1'b0) begin n_fail++; $display("FAIL clear_ready: job_ready_o=%b required 0", job_ready_o); end
    exp_ids.delete();
    tick(1);
    clear_i = 1'b0;
    @(negedge clk);
    n_checks++; if (queue_count_o !== '0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL clear_state: count=%0d busy_o=%b required 0 0", queue_count_o, busy_o); end
    tick(1);
    ch_sink_done_i = 2'b11;
    tick(1);
    ch_sink_done_i = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (done_o !== 1'b0 || ch_start_o !== 2'b00) begin n_fail++; $display("FAIL clear_quiet: done_o=%b ch_start_o=%b required 0 00", done_o, ch_start_o); end
      tick(1);
    end
  endtask

  task automatic test_reset_mid_job();
    bit ok;
    push_job(2'b11, 8'd2, 4'd13);
    wait_start(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_start: no ch_start_o seen, required 11"); end
    tick(1);
    push_job(2'b01, 8'd0, 4'd14);
    push_job(2'b00, 8'd0, 4'd15);
    rst_i = 1'b1;
    @(negedge clk);
    n_checks++; if (queue_count_o !== '0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_state: count=%0d busy_o=%b required 0 0", queue_count_o, busy_o); end
    n_checks++; if (job_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_ready: job_ready_o=%b required 0", job_ready_o); end
    exp_ids.delete();
    tick(1);
    rst_i = 1'b0;
    tick(1);
    ch_sink_done_i = 2'b11;
    @(negedge clk);
    n_checks++; if (job_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready_back: job_ready_o=%b required 1", job_ready_o); end
    tick(1);
    ch_sink_done_i = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_quiet: done_o=%b busy_o=%b required 0 0", done_o, busy_o); end
      tick(1);
    end
  endtask

  task automatic test_end();
    n_checks++;
    if (exp_ids.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d expected completions missing, required 0", exp_ids.size());
    end
  endtask

  initial begin
    rst_i           = 1'b1;
    clear_i         = 1'b0;
    job_valid_i     = 1'b0;
    job_ch_mask_i   = '0;
    job_repeat_i    = '0;
    job_id_i        = '0;
    ch_sink_done_i  = '0;
    ch_fifo_empty_i = '1;
    test_reset();
    test_single_pass();
    test_repeat();
    test_mask_zero();
    test_fifo_not_empty();
    test_back_to_back();
    test_clear();
    test_reset_mid_job();
    test_end();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/datamover_job_ctrl.md
DATAMOVER_JOB_CTRL -- requirements
Module: datamover_job_ctrl

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of streamer channels (source+sink pairs), 1..8.
REQ-002 SHALL have parameter QUEUE_DEPTH, default 4: job queue entries, power of two, >=2.
REQ-003 SHALL have parameter REP_W, default 8: width of the per-job repeat count.
REQ-004 SHALL have parameter ID_W, default 4: width of the job tag.
REQ-005 SHALL have parameter N_CORES, default 8: width of the event output.
REQ-006 SHALL use one clock; reset is asynchronous and active-high.
REQ-007 SHALL have ports, in this order:
  clk_i  in  1  clock;
  rst_i  in  1  async active-high reset;
  clear_i  in  1  sync soft clear;
  job_valid_i  in  1  descriptor valid;
  job_ready_o  out  1  descriptor accepted when valid&ready;
  job_ch_mask_i  in  N_CH  channels used by the job;
  job_repeat_i  in  REP_W  pass count, where 0 means 1;
  job_id_i  in  ID_W  job tag;
  ch_start_o  out  N_CH  one-cycle start pulse per channel;
  ch_sink_done_i  in  N_CH  sink done pulse per channel;
  ch_fifo_empty_i  in  N_CH  channel TCDM FIFO empty;
  done_o  out  1  one-cycle job-complete pulse;
  done_id_o  out  ID_W  tag of completed job, valid with done_o;
  evt_o  out  N_CORES  event, all bits high with done_o;
  busy_o  out  1  FSM not IDLE or queue not empty;
  queue_count_o  out  clog2(QUEUE_DEPTH)+1  queued jobs.

Function
REQ-008 SHALL queue {mask, repeat, id} in a FIFO; job_ready_o = !full, with no push-through when full.
REQ-009 SHALL, when pushing and popping in the same cycle, apply both operations, leaving queue_count_o unchanged.
REQ-010 SHALL implement FSM states IDLE, STARTING, WORKING, FINISHED.
REQ-011 SHALL, in IDLE with queue non-empty, pop the head into working registers (mask, passes-remaining = max(repeat,1)-1, id) and go to the next state:
  to FINISHED if the mask is zero;
  to STARTING otherwise.
REQ-012 SHALL, in STARTING, drive ch_start_o = working mask for exactly one cycle, clear the per-channel done-seen flags, and go to WORKING.
REQ-013 SHALL, in WORKING, OR ch_sink_done_i of masked channels into the sticky done-seen flags; ch_sink_done_i on unmasked channels and in non-WORKING states is ignored.
REQ-014 SHALL detect a pass complete when, for every masked channel, (done-seen | ch_sink_done_i) & ch_fifo_empty_i holds in the same cycle.
REQ-015 SHALL, on pass complete, take one of two transitions:
  passes-remaining > 0: decrement it and go to STARTING;
  passes-remaining = 0: go to FINISHED.
REQ-016 SHALL, in FINISHED, assert done_o, done_id_o = working id, and evt_o = all ones for exactly one cycle, then go to IDLE.
REQ-017 SHALL drive done_id_o = 0 when done_o is low.
REQ-018 SHALL meet the following latencies:
  job accepted into an empty queue in an IDLE cycle N gives ch_start_o high in cycle N+2;
  pass complete in cycle M gives done_o in cycle M+1, or ch_start_o in cycle M+1 for the next pass;
  back-to-back queued jobs have one IDLE cycle between them.
REQ-019 SHALL, on clear_i, do all of the following on the next edge:
  flush the queue;
  return the FSM to IDLE;
  clear the working registers and flags;
  suppress any pending done_o/evt_o.
REQ-020 SHALL keep job_ready_o low while clear_i is high.
REQ-021 SHALL, on rst_i asserted mid-job, abandon the job immediately; no done_o is ever issued for it.

Reset
REQ-022 SHALL reset all outputs to 0, except job_ready_o, which goes to 1 one cycle after rst_i deasserts.
REQ-023 SHALL reset FSM = IDLE, queue pointers/count = 0, and working registers = 0.

Structure
REQ-024 SHALL place the FSM state enum and a job descriptor struct {mask, repeat, id} in datamover_package.
REQ-025 SHALL implement the queue as one sub-module, datamover_job_fifo (depth/width parametrised, sync flush input).

Verification
REQ-026 SHALL cover: N_CH=2, job mask=2'b11, repeat=0, id=5; ch0 done at cycle 10, ch1 done at cycle 14 with FIFOs empty -> single ch_start_o=2'b11, then done_o with id 5 at cycle 15.
REQ-027 SHALL cover: repeat=3, mask=2'b01 -> exactly 3 ch_start_o pulses, each 1 cycle after the previous pass completes; one done_o.
REQ-028 SHALL cover: 5 jobs pushed back-to-back with QUEUE_DEPTH=4 and FSM stalled in WORKING -> job_ready_o low after the 4th push, queue_count_o=4; 5th job accepted after the 1st pop.
REQ-029 SHALL cover: mask=0, id=9 -> no ch_start_o; done_o with id 9 two cycles after acceptance.
REQ-030 SHALL cover: ch0 sink done while ch_fifo_empty_i[0]=0 for 3 cycles -> done_o only after the FIFO is empty.
REQ-031 SHALL cover: clear_i mid-WORKING with 2 jobs queued -> queue_count_o=0, busy_o=0 next cycle, no done_o; rst_i mid-job -> same.
